vga_sync_checker: RTL
=====================

// Module: vga_sync_checker
// PURPOSE
//  Receive-side counterpart of the VGA timing generator. Samples hs/vs/r/g/b on pixel ticks and
//  recovers col/row. Checks 640x480@60 timing, locks to the stream, and captures one probed pixel.
//  Sits beside the display path as an on-chip monitor and simulation scoreboard for the video output.
// PARAMETERS
//  H_VISIBLE 640 ; H_FRONT 16 ; H_SYNC 96 ; H_BACK 48   (pixel ticks; H_TOTAL = sum = 800)
//  V_VISIBLE 480 ; V_FRONT 10 ; V_SYNC 2  ; V_BACK 33   (lines; V_TOTAL = sum = 525)
//  SYNC_ACTIVE_LOW 1 : 1 = hs/vs asserted when 0; 0 = asserted when 1
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  pix_en       in   1   pixel-tick strobe (one clk wide); inputs sampled only when 1
//  hs, vs       in   1   sync inputs under test
//  r, g, b      in   4   colour inputs under test
//  probe_x      in  10   probed column (0..639)
//  probe_y      in   9   probed row (0..479)
//  locked       out  1   one clean frame seen; tracking
//  active       out  1   locked and sampled pixel inside visible window
//  col          out 10   recovered column (valid when active)
//  row          out  9   recovered row (valid when active)
//  frame_done   out  1   1-clk pulse at each locked frame start
//  frame_cnt    out 16   locked frame counter; wraps 65535 -> 0
//  probe_rgb    out 12   {r,g,b} captured at probe point
//  probe_valid  out  1   1-clk pulse when probe_rgb updated
//  err_hsync    out  1   sticky horizontal timing violation
//  err_vsync    out  1   sticky vertical timing violation
//  frame_crc    out 16   CRC of last complete frame's active pixels (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, state HUNT, counters 0. Reset overrides every other event.
//  - pix_en=0: no state/counter change; pulse outputs 0. Inputs are same clock domain; no synchronizer.
//  - Edges: hs_start/hs_end = assert/deassert of hs versus its value at the previous tick.
//  - hcnt: 0 on hs_start tick, else +1 per tick.
//  - vs level sampled at each hs_start. vs_start = asserted there, deasserted at the previous hs_start.
//    vs_end is the reverse.
//  - vcnt: 0 on vs_start line, else +1 per hs_start.
//  - Visible window: hcnt in [H_SYNC+H_BACK, +H_VISIBLE); vcnt in [V_SYNC+V_BACK, +V_VISIBLE).
//    col = hcnt-(H_SYNC+H_BACK); row = vcnt-(V_SYNC+V_BACK).
//  - Latency: col/row/active/probe outputs registered 1 clk after the sampling tick.
//  - FSM: HUNT --vs_start--> ALIGN --hs_start--> CHECK --next vs_start, no error--> LOCKED.
//    CHECK/LOCKED --any violation--> HUNT (locked=0 same clk the err bit sets).
//  - Violations, checked only in CHECK/LOCKED:
//    hs_start with old hcnt != H_TOTAL-1        -> err_hsync
//    hs_end with hcnt != H_SYNC                 -> err_hsync
//    vs_start with old vcnt != V_TOTAL-1        -> err_vsync
//    vs_end with vcnt != V_SYNC                 -> err_vsync
//  - Err bits are sticky until reset. Relock after a later clean frame does not clear them.
//  - frame_done: pulses, and frame_cnt increments, on vs_start while LOCKED.
//    A violation on the same tick wins: no pulse, no increment.
//  - Probe: active && col==probe_x && row==probe_y -> probe_rgb <= {r,g,b}, probe_valid pulse.
//    Out-of-range probe never fires.
// CONFIGURATION
//  VGA_CHECK_CRC_EN defined:
//    CRC-16-CCITT (poly 0x1021, init 0xFFFF) over {r,g,b}, MSB first, one 12-bit word per active pixel.
//    Latched into frame_crc on frame_done; running CRC re-inits there and on any unlock.
//  Undefined: frame_crc tied to 16'h0000, no CRC logic.
// TESTING
//  - Ideal 640x480 stream, pix_en every 4th clk, 3 frames -> locked=1 at 2nd vs_start; err bits 0;
//    frame_cnt=1 after 3rd vs_start.
//  - Locked, probe=(0,0), first visible pixel rgb=12'hF00 -> probe_rgb=F00, one probe_valid per frame;
//    last active pixel gives col=639,row=479.
//  - Locked, one hsync stretched to 97 ticks -> err_hsync=1, locked=0.
//    Relock after 1 clean frame; err_hsync stays 1.
//  - Locked, one frame of 526 lines -> err_vsync=1, no frame_done that vs_start, frame_cnt unchanged.
//  - reset pulsed mid-line while locked -> next clk all outputs 0, relock needs full HUNT sequence.
//  - pix_en held 0 for 1000 clks mid-line -> outputs frozen, no error on resume.
//  - Under VGA_CHECK_CRC_EN, frame of all 12'h000 -> frame_crc equals golden model value.
//    Without the macro, frame_crc=0.

Source files
------------

// File: rtl/vga_sync_checker.sv
// Receive-side VGA timing monitor: recovers col/row from hs/vs, checks timing, locks, probes one pixel.
// Optional frame CRC over active pixels is built only when VGA_CHECK_CRC_EN is defined.
module vga_sync_checker #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic [9:0]  probe_x,
  input  logic [8:0]  probe_y,
  output logic        locked,
  output logic        active,
  output logic [9:0]  col,
  output logic [8:0]  row,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [11:0] probe_rgb,
  output logic        probe_valid,
  output logic        err_hsync,
  output logic        err_vsync,
  output logic [15:0] frame_crc,
  output logic [1:0]  fsm_state
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_ACT0 = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT1 = 10'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0] V_ACT0 = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT1 = 10'(V_SYNC + V_BACK + V_VISIBLE);

  typedef enum logic [1:0] {HUNT, ALIGN, CHECK, LOCKED} state_t;

  state_t      state, state_n;
  logic        hs_prev, vs_line;
  logic [9:0]  hcnt, vcnt, hcnt_n, vcnt_n;
  logic        hs_a, vs_a, hs_start, hs_end, vs_start, vs_end;
  logic        checking, h_err, v_err, done, in_win, act_n, hit;
  logic [9:0]  col_n;
  logic [8:0]  row_n;

  assign fsm_state = state;

  // Edges are judged in "asserted" sense so polarity only matters here.
  always_comb begin
    hs_a     = SYNC_ACTIVE_LOW ? ~hs : hs;
    vs_a     = SYNC_ACTIVE_LOW ? ~vs : vs;
    hs_start = hs_a & ~hs_prev;
    hs_end   = ~hs_a & hs_prev;
    vs_start = hs_start & vs_a & ~vs_line;
    vs_end   = hs_start & ~vs_a & vs_line;
    hcnt_n   = hs_start ? 10'd0 : hcnt + 10'd1;
    vcnt_n   = hs_start ? (vs_start ? 10'd0 : vcnt + 10'd1) : vcnt;
    checking = (state == CHECK) || (state == LOCKED);
    h_err    = checking & ((hs_start & (hcnt != H_LAST)) | (hs_end & (hcnt_n != H_SYNC_W)));
    v_err    = checking & ((vs_start & (vcnt != V_LAST)) | (vs_end & (vcnt_n != V_SYNC_W)));
    state_n  = state;
    if (h_err || v_err) begin
      state_n = HUNT;
    end else begin
      case (state)
        HUNT:    if (vs_start) state_n = ALIGN;
        ALIGN:   if (hs_start) state_n = CHECK;
        CHECK:   if (vs_start) state_n = LOCKED;
        default: state_n = LOCKED;
      endcase
    end
    done   = (state == LOCKED) & vs_start & ~h_err & ~v_err;
    in_win = (hcnt_n >= H_ACT0) && (hcnt_n < H_ACT1) && (vcnt_n >= V_ACT0) && (vcnt_n < V_ACT1);
    act_n  = (state_n == LOCKED) && in_win;
    col_n  = hcnt_n - H_ACT0;
    row_n  = 9'(vcnt_n - V_ACT0);
    hit    = act_n && (col_n == probe_x) && (row_n == probe_y);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      hs_prev     <= 1'b0;
      vs_line     <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      locked      <= 1'b0;
      active      <= 1'b0;
      col         <= '0;
      row         <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
      err_hsync   <= 1'b0;
      err_vsync   <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      probe_valid <= 1'b0;
      if (pix_en) begin
        hs_prev   <= hs_a;
        if (hs_start) vs_line <= vs_a;
        hcnt      <= hcnt_n;
        vcnt      <= vcnt_n;
        state     <= state_n;
        locked    <= (state_n == LOCKED);
        active    <= act_n;
        err_hsync <= err_hsync | h_err;
        err_vsync <= err_vsync | v_err;
        if (act_n) begin
          col <= col_n;
          row <= row_n;
        end
        if (done) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
        end
        if (hit) begin
          probe_rgb   <= {r, g, b};
          probe_valid <= 1'b1;
        end
      end
    end
  end

`ifdef VGA_CHECK_CRC_EN
  logic [15:0] crc_run;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 11; i >= 0; i--) begin
      x = (x[15] ^ d[i]) ? ((x << 1) ^ 16'h1021) : (x << 1);
    end
    return x;
  endfunction

  // Running CRC restarts whenever tracking is lost so a partial frame never latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_run   <= 16'hFFFF;
      frame_crc <= '0;
    end else if (pix_en) begin
      if (state_n != LOCKED) begin
        crc_run <= 16'hFFFF;
      end else if (done) begin
        frame_crc <= crc_run;
        crc_run   <= 16'hFFFF;
      end else if (act_n) begin
        crc_run <= crc_step(crc_run, {r, g, b});
      end
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule
